// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: (a - b - bin) mod 2^WIDTH, LSB first, one
// full-subtractor cell evaluated per clock, with a start/busy/done handshake.

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    // Full subtractor from two half subtractors; returns {borrow_out, difference}.
    function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic bi);
        logic hd;
        logic hb;
        hd = x ^ y;
        hb = ~x & y;
        return {hb | (~hd & bi), hd ^ bi};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       cell_s;

    // Next-state and datapath: load on accepted start, one cell per SHIFT cycle.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        cell_s   = fs_cell(a_q[0], b_q[0], br_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = cell_s[1];
                acc_d = {cell_s[0], acc_q[WIDTH-1:1]};
                // Results are published only on the final bit so diff holds meanwhile.
                if (cnt_q == LAST_BIT) begin
                    diff_d   = {cell_s[0], acc_q[WIDTH-1:1]};
                    borrow_d = cell_s[1];
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    busy_d   = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 directed/random and WIDTH=2 exhaustive.

module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, bin8, busy8, done8, borrow8;
    logic [7:0] a8, b8, diff8;
    logic       start2, bin2, busy2, done2, borrow2;
    logic [1:0] a2, b2, diff2;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2)
    );

    typedef struct packed {
        logic [7:0] diff;
        logic       borrow;
        int         cyc;
    } exp_t;

    exp_t       q8[$];
    exp_t       q2[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         cyc        = 0;
    int         free_cyc[2];
    int         busy_run[2];
    logic [7:0] last_diff[2];
    logic       last_borrow[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int width_of(input int u);
        return (u == 0) ? 8 : 2;
    endfunction

    // Reference: plain integer arithmetic on the operands
    function automatic exp_t model(input int u, input logic [7:0] a, input logic [7:0] b, input logic bin);
        exp_t e;
        int   mask;
        int   av;
        int   bv;
        mask     = (1 << width_of(u)) - 1;
        av       = int'(a) & mask;
        bv       = int'(b) & mask;
        e.diff   = 8'((av - bv - int'(bin)) & mask);
        e.borrow = (av < bv + int'(bin));
        e.cyc    = 0;
        return e;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input int u, input logic s, input logic [7:0] a, input logic [7:0] b, input logic bin);
        if (u == 0) begin
            start8 = s; a8 = a; b8 = b; bin8 = bin;
        end else begin
            start2 = s; a2 = a[1:0]; b2 = b[1:0]; bin2 = bin;
        end
    endtask

    task automatic issue(input int u, input logic [7:0] a, input logic [7:0] b, input logic bin);
        exp_t e;
        while (cyc < free_cyc[u]) step(1);
        drive(u, 1'b1, a, b, bin);
        e       = model(u, a, b, bin);
        e.cyc   = cyc + 1 + width_of(u);
        free_cyc[u] = e.cyc;
        if (u == 0) q8.push_back(e);
        else        q2.push_back(e);
        step(1);
        drive(u, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic ghost(input int u);
        drive(u, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
        step(1);
        drive(u, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    // Monitor: pop and compare on every done, check hold, exclusivity and busy length.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int u = 0; u < 2; u++) begin
                logic       bz;
                logic       dn;
                logic       bw;
                logic [7:0] df;
                exp_t       e;
                int         qs;
                bz = (u == 0) ? busy8 : busy2;
                dn = (u == 0) ? done8 : done2;
                bw = (u == 0) ? borrow8 : borrow2;
                df = (u == 0) ? diff8 : {6'b000000, diff2};
                qs = (u == 0) ? q8.size() : q2.size();
                if (bz && dn) check("busy_done_excl", 1, 0);
                if (dn) begin
                    if (qs == 0) begin
                        check("spurious_done", 1, 0);
                    end else begin
                        if (u == 0) e = q8.pop_front();
                        else        e = q2.pop_front();
                        check("done_cycle", cyc, e.cyc);
                        check("diff", df, e.diff);
                        check("borrow", bw, e.borrow);
                        last_diff[u]   = e.diff;
                        last_borrow[u] = e.borrow;
                    end
                end else begin
                    check("diff_hold", df, last_diff[u]);
                    check("borrow_hold", bw, last_borrow[u]);
                    if (qs != 0) begin
                        e = (u == 0) ? q8[0] : q2[0];
                        if (cyc > e.cyc) check("done_missing", cyc, e.cyc);
                    end
                end
                if (bz) begin
                    busy_run[u]++;
                end else begin
                    if (busy_run[u] != 0) check("busy_len", busy_run[u], width_of(u));
                    busy_run[u] = 0;
                end
            end
        end
    end

    initial begin
        int g;
        rst_n = 1'b1;
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int u = 0; u < 2; u++) begin
            free_cyc[u] = 0; busy_run[u] = 0; last_diff[u] = 8'h00; last_borrow[u] = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_diff8", diff8, 0);
        check("rst_borrow8", borrow8, 0);
        check("rst_busy2", busy2, 0);
        check("rst_diff2", diff2, 0);
        step(2);
        rst_n = 1'b1;
        free_cyc[0] = cyc;
        free_cyc[1] = cyc;

        issue(0, 8'h05, 8'h03, 1'b0);
        step(12);
        issue(0, 8'h03, 8'h05, 1'b0);
        issue(0, 8'h00, 8'h00, 1'b1);
        step(11);
        issue(0, 8'h80, 8'h01, 1'b0);
        issue(0, 8'hFF, 8'hFF, 1'b0);
        step(12);
        issue(0, 8'h10, 8'h01, 1'b0);
        step(2);
        ghost(0);
        ghost(0);
        step(10);

        issue(0, 8'($urandom), 8'($urandom), 1'($urandom));
        step(3);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_diff", diff8, 0);
        check("abort_borrow", borrow8, 0);
        q8.delete();
        last_diff[0]   = 8'h00;
        last_borrow[0] = 1'b0;
        busy_run[0]    = 0;
        @(posedge clk);
        step(1);
        rst_n = 1'b1;
        free_cyc[0] = cyc;
        free_cyc[1] = cyc;
        step(12);

        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 3));
            issue(0, 8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                step($urandom_range(0, 5));
                ghost(0);
            end
        end

        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    issue(1, 8'(a), 8'(b), 1'(c));
                end
            end
        end

        g = 0;
        while ((q8.size() != 0 || q2.size() != 0) && g < 200) begin
            step(1);
            g++;
        end
        check("drain_pending", q8.size() + q2.size(), 0);
        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
